// File: rtl/invsqrt_pkg.sv
// invsqrt_pkg: shared float format and controller state types for the inverse-sqrt stream block
package invsqrt_pkg;
  localparam int FP_W  = 31;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  typedef logic [FP_W-1:0] float31_t;
  typedef enum logic {FLUSH, RUN} state_e;
endpackage

// File: rtl/invsqrt_result_fifo.sv
// invsqrt_result_fifo: in-order result buffer with wrap-bit pointers; head reads as zero when empty
module invsqrt_result_fifo
  import invsqrt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  float31_t                 din,
  output float31_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  float31_t    mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end
  assign empty = wr_q == rd_q;
  assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign count = wr_q - rd_q;
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/invsqrt_stream_ctrl.sv
// invsqrt_stream_ctrl: credit-gated valid/ready wrapper around a no-backpressure inverse-sqrt pipeline
module invsqrt_stream_ctrl
  import invsqrt_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     s_valid,
  output logic     s_ready,
  input  float31_t s_data,
  output logic     p_valid,
  output float31_t p_data,
  input  float31_t p_result,
  input  logic     p_ready,
  output logic     m_valid,
  input  logic     m_ready,
  output float31_t m_data,
  output logic     err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(PIPE_LAT+1);
  state_e      state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] credit_q, credit_d;
  logic        p_valid_q, p_valid_d, err_q, err_d;
  float31_t    p_data_q, p_data_d;
  logic        run, hs, pop, push, wr_ok, full, empty;
  logic [AW:0] count;
  assign s_ready = run && (credit_q < CW'(DEPTH));
  assign p_valid = p_valid_q;
  assign p_data  = p_data_q;
  assign err     = err_q;
  assign m_valid = !empty;
  // A result is only accepted if some issued operand has not yet landed in the FIFO
  always_comb begin
    run       = state_q == RUN;
    hs        = s_valid && s_ready;
    pop       = m_valid && m_ready;
    wr_ok     = (!full || pop) && (CW'(count) != credit_q);
    push      = run && p_ready && wr_ok;
    err_d     = err_q || (run && p_ready && !wr_ok);
    cnt_d     = run ? cnt_q : cnt_q - LW'(1);
    state_d   = (run || cnt_d == '0) ? RUN : FLUSH;
    credit_d  = credit_q + CW'(hs) - CW'(pop);
    p_valid_d = hs;
    p_data_d  = hs ? s_data : p_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FLUSH;
      cnt_q     <= LW'(PIPE_LAT);
      credit_q  <= '0;
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      credit_q  <= credit_d;
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      err_q     <= err_d;
    end
  end
  invsqrt_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (p_result),
    .dout  (m_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_invsqrt_stream_ctrl.sv
// tb_invsqrt_stream_ctrl: directed bench with a latency-5 magic-constant pipeline model and result scoreboard
module tb_invsqrt_stream_ctrl;
  import invsqrt_pkg::*;
  localparam int DEPTH = 8;
  localparam int PL    = 5;
  localparam int L     = 5;
  logic     clk = 0, rst_n = 0, s_valid = 0, m_ready = 0, frc = 0;
  logic     s_ready, p_valid, p_ready, m_valid, err;
  float31_t s_data = '0, frc_val = '0, p_data, p_result, m_data;
  logic [L-1:0] pv = '0;
  float31_t pd [L];
  int pass_cnt = 0, tot = 0, cyc = 0, npop = 0, first_pop = 0, last_pop = 0, lat = 0, acc = 0;
  float31_t sb [$];
  logic [31:0] hold, diff;

  function automatic float31_t f(input float31_t x);
    logic [31:0] y;
    y = 32'h5F3759DF - ({1'b0, x} >> 1);
    return y[30:0];
  endfunction

  always #5 clk = ~clk;
  // Pipeline model: registers are never reset, so residue survives a controller reset
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], p_valid};
    pd[0] <= p_data;
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign p_ready  = pv[L-1] | frc;
  assign p_result = frc ? frc_val : f(pd[L-1]);

  invsqrt_stream_ctrl #(.DEPTH(DEPTH), .PIPE_LAT(PL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .p_valid  (p_valid),
    .p_data   (p_data),
    .p_result (p_result),
    .p_ready  (p_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    if (s_valid && s_ready) sb.push_back(f(s_data));
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        tot++;
        $error("FAIL spurious_pop: got %h expected no result", m_data);
      end else chk("m_data", 32'(m_data), 32'(sb.pop_front()));
      if (npop == 0) first_pop = cyc;
      last_pop = cyc;
      npop++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_p_valid"}, 32'(p_valid), 0);
    chk({tag, "_p_data"}, 32'(p_data), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_credit"}, 32'(dut.credit_q), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1;
    frc = 1;
    frc_val = 31'h12345678;
    for (int c = 1; c <= PL; c++) begin
      step();
      chk("flush_s_ready", 32'(s_ready), 32'(c == PL));
      chk("flush_m_valid", 32'(m_valid), 0);
      chk("flush_err", 32'(err), 0);
    end
    frc = 0;
    chk("flush_count", 32'(dut.u_fifo.count), 0);
    m_ready = 1;
    s_valid = 1;
    s_data  = 31'h40800000;
    chk("single_s_ready", 32'(s_ready), 1);
    step();
    s_valid = 0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("single_latency", 32'(lat), L + 2);
    diff = (32'(m_data) > 32'h3F000000) ? 32'(m_data) - 32'h3F000000 : 32'h3F000000 - 32'(m_data);
    chk("single_tolerance", 32'(diff < 32'h00100000), 1);
    step();
    chk("single_npop", 32'(npop), 1);
    npop = 0;
    for (int i = 0; i < 32; i++) begin
      s_valid = 1;
      s_data  = 31'h3F800000 + 31'(i << 16);
      chk("stream_s_ready", 32'(s_ready), 1);
      step();
    end
    s_valid = 0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("stream_npop", 32'(npop), 32);
    chk("stream_consecutive", 32'(last_pop - first_pop + 1), 32);
    chk("stream_sb_empty", 32'(sb.size()), 0);
    m_ready = 0;
    npop = 0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1;
      s_data  = 31'h41000000 + 31'(acc << 12);
      if (s_ready) acc++;
      step();
    end
    chk("bp_accepted", 32'(acc), 8);
    chk("bp_s_ready", 32'(s_ready), 0);
    chk("bp_credit", 32'(dut.credit_q), 8);
    chk("bp_count", 32'(dut.u_fifo.count), 8);
    hold = 32'(m_data);
    step();
    chk("bp_hold_stable", 32'(m_data), hold);
    s_valid = 0;
    m_ready = 1;
    chk("bp_s_ready_pre_pop", 32'(s_ready), 0);
    step();
    chk("bp_s_ready_post_pop", 32'(s_ready), 1);
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("bp_npop", 32'(npop), 8);
    m_ready = 0;
    chk("err_credit0", 32'(dut.credit_q), 0);
    frc = 1;
    frc_val = 31'h0ABCDEF0;
    step();
    frc = 0;
    chk("err_set", 32'(err), 1);
    chk("err_m_valid", 32'(m_valid), 0);
    chk("err_count", 32'(dut.u_fifo.count), 0);
    repeat (3) step();
    chk("err_sticky", 32'(err), 1);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1;
      s_data  = 31'h40000000 + 31'(i << 20);
      step();
    end
    s_valid = 0;
    repeat (8) step();
    chk("mid_stored", 32'(dut.u_fifo.count), 3);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      s_data  = 31'h40400000 + 31'(i << 20);
      step();
    end
    s_valid = 0;
    rst_n = 0;
    #1;
    chk_reset_vals("mid");
    sb.delete();
    step();
    step();
    rst_n = 1;
    repeat (PL) step();
    chk("mid_s_ready", 32'(s_ready), 1);
    chk("mid_m_valid", 32'(m_valid), 0);
    chk("mid_err", 32'(err), 0);
    npop = 0;
    m_ready = 1;
    s_valid = 1;
    s_data  = 31'h3E800000;
    step();
    s_valid = 0;
    repeat (12) step();
    chk("mid_npop", 32'(npop), 1);
    chk("mid_m_valid_end", 32'(m_valid), 0);
    chk("mid_err_end", 32'(err), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
